// File: rtl/bus_arbiter_rr.sv
// Round-robin shared-bus arbiter with optional hold-time preemption.
// Grants the memory bus to one cache at a time, inserts a one-cycle
// turnaround after every tenure, and advances the round-robin pointer
// past the last owner so that every requester is eventually served.
module bus_arbiter_rr #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               bus_busy,
  output logic [ID_W-1:0]    owner_id,
  output logic               preempt
);

  // The hold counter must be able to hold MAX_HOLD itself, since it saturates there.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_next;
  logic [ID_W-1:0]     owner_next;
  logic [ID_W-1:0]     pick;
  logic                pick_valid;
  logic [HOLD_W-1:0]   hold_cnt, hold_next;
  logic [NUM_REQ-1:0]  gnt_next;
  logic [NUM_REQ-1:0]  owner_mask;
  logic [NUM_REQ-1:0]  others;
  logic                busy_next;
  logic                preempt_next;
  logic                hold_limit;

  // Round-robin search: walk from rr_ptr upward (wrapping); the lowest offset with a request wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick       = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        pick_valid = 1'b1;
      end
    end
  end

  // Pending requests from cores other than the owner, and whether the owner has used up its tenure.
  always_comb begin
    owner_mask = NUM_REQ'(1) << owner_id;
    others     = req & ~owner_mask;
    hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  end

  // Next-state and next-output logic; a release by the owner takes precedence over preemption.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    busy_next    = bus_busy;
    owner_next   = owner_id;
    preempt_next = 1'b0;
    hold_next    = hold_cnt;
    rr_ptr_next  = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_next   = NUM_REQ'(1) << pick;
          owner_next = pick;
          hold_next  = '0;
          busy_next  = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_id]) begin
          gnt_next   = '0;
          busy_next  = 1'b0;
          state_next = TURN;
        end else if (hold_limit && (others != '0)) begin
          gnt_next     = '0;
          busy_next    = 1'b0;
          preempt_next = 1'b1;
          state_next   = TURN;
        end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      TURN: begin
        gnt_next    = '0;
        busy_next   = 1'b0;
        rr_ptr_next = ID_W'((int'(owner_id) + 1) % NUM_REQ);
        state_next  = IDLE;
      end
      default: begin
        gnt_next   = '0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at the same edge, including a live grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      bus_busy <= 1'b0;
      owner_id <= '0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      bus_busy <= busy_next;
      owner_id <= owner_next;
      preempt  <= preempt_next;
      hold_cnt <= hold_next;
      rr_ptr   <= rr_ptr_next;
    end
  end

endmodule
